shift_subtract_divider: RTL

- Sequential restoring divider: splits a 2N-bit product back into factors by dividing it by an N-bit divisor.
- Returns a 2N-bit quotient and an N-bit remainder.
- It is the inverse-direction companion of the team's 4x4 array multiplier; datapath widths match its 8-bit product and 4-bit operands at default N=4.
- Valid/ready on both sides; one quotient bit resolved per clock.

---
 rtl/shift_subtract_divider_if.sv | 25 ++
 rtl/shift_subtract_divider.sv | 98 +++++++++
 2 files changed

// File: rtl/shift_subtract_divider_if.sv
// Valid/ready handshake bundle for the shift-subtract divider: operand request
// side and result side share one interface.
interface shift_subtract_divider_if #(
   parameter int N = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [2*N-1:0]   dividend;
   logic [N-1:0]     divisor;
   logic             out_valid;
   logic             out_ready;
   logic [2*N-1:0]   quotient;
   logic [N-1:0]     remainder;
   logic             div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/shift_subtract_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, MSB first, with valid/ready on both sides.
module shift_subtract_divider #(
   parameter int N = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   shift_subtract_divider_if.slave bus
);
   localparam int CW = $clog2(2*N) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   count_q;
   logic [2*N-1:0]  dvd_q;
   logic [N-1:0]    dsr_q;
   logic [N-1:0]    r_q;
   logic [2*N-1:0]  quo_q;
   logic [N-1:0]    rem_q;
   logic            dbz_q;
   logic            out_valid_q;

   logic [N:0]      r_sh;
   logic [N:0]      diff;
   logic            bit_d;
   logic [N-1:0]    r_d;
   logic [2*N-1:0]  dvd_d;

   // The partial remainder stays below the divisor, so the top bit of the
   // (N+1)-bit difference is a clean borrow flag: no borrow means R' >= divisor.
   always_comb begin
      r_sh  = {r_q, dvd_q[2*N-1]};
      diff  = r_sh - {1'b0, dsr_q};
      bit_d = ~diff[N];
      r_d   = bit_d ? diff[N-1:0] : r_sh[N-1:0];
      dvd_d = {dvd_q[2*N-2:0], bit_d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         r_q         <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dvd_q   <= bus.dividend;
                  dsr_q   <= bus.divisor;
                  r_q     <= '0;
                  count_q <= '0;
                  dbz_q   <= (bus.divisor == '0);
                  state_q <= RUN;
               end
            end
            RUN: begin
               // A zero divisor spends exactly one cycle here before reporting.
               if (dbz_q) begin
                  quo_q       <= '1;
                  rem_q       <= dvd_q[N-1:0];
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  dvd_q   <= dvd_d;
                  r_q     <= r_d;
                  count_q <= count_q + 1'b1;
                  if (count_q == CW'(2*N-1)) begin
                     quo_q       <= dvd_d;
                     rem_q       <= r_d;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule
